// File: rtl/mem_arbiter.sv
// Shares one RAM port between instruction fetch and data load/store.
// Data has priority; a pending fetch is forced through after STARVE_LIMIT data grants.
module mem_arbiter #(
   parameter int STARVE_LIMIT = 4,
   parameter int RETRY_MAX    = 3,
   parameter int TIMEOUT      = 64
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        iREN,
   input  logic [31:0] iaddr,
   output logic [31:0] iload,
   output logic        ihit,
   input  logic        dREN,
   input  logic        dWEN,
   input  logic [31:0] daddr,
   input  logic [31:0] dstore,
   output logic [31:0] dload,
   output logic        dhit,
   output logic        ramREN,
   output logic        ramWEN,
   output logic [31:0] ramaddr,
   output logic [31:0] ramstore,
   input  logic [31:0] ramload,
   input  logic [1:0]  ramstate,
   output logic        mem_err
);

   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam int RW = $clog2(RETRY_MAX + 1);
   localparam int TW = $clog2(TIMEOUT);

   localparam logic [SW-1:0] SLIM = SW'(STARVE_LIMIT);
   localparam logic [RW-1:0] RLIM = RW'(RETRY_MAX);
   localparam logic [TW-1:0] TLIM = TW'(TIMEOUT - 1);

   localparam logic [1:0] RS_ACCESS = 2'd2;
   localparam logic [1:0] RS_ERROR  = 2'd3;

   typedef enum logic [1:0] {IDLE, D_ACC, I_ACC} state_t;

   state_t        state, next_state;
   logic [SW-1:0] starve_cnt, starve_nxt;
   logic [RW-1:0] retry_cnt, retry_nxt;
   logic [TW-1:0] tmo_cnt, tmo_nxt;
   logic          abort;
   logic          own;
   logic          d_req;
   logic          starved;

   assign d_req   = dREN | dWEN;
   assign starved = iREN && (starve_cnt == SLIM);

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state      <= IDLE;
         starve_cnt <= '0;
         retry_cnt  <= '0;
         tmo_cnt    <= '0;
         mem_err    <= 1'b0;
      end else begin
         state      <= next_state;
         starve_cnt <= starve_nxt;
         retry_cnt  <= retry_nxt;
         tmo_cnt    <= tmo_nxt;
         mem_err    <= mem_err | abort;
      end
   end

   always_comb begin
      next_state = state;
      starve_nxt = starve_cnt;
      retry_nxt  = retry_cnt;
      tmo_nxt    = tmo_cnt;
      abort      = 1'b0;
      own        = 1'b0;
      ramREN     = 1'b0;
      ramWEN     = 1'b0;
      ramaddr    = '0;
      ramstore   = '0;
      ihit       = 1'b0;
      dhit       = 1'b0;
      iload      = '0;
      dload      = '0;

      case (state)
         IDLE: begin
            retry_nxt = '0;
            tmo_nxt   = '0;
            if (d_req && !starved) begin
               next_state = D_ACC;
               if (iREN) starve_nxt = (starve_cnt == SLIM) ? starve_cnt : starve_cnt + SW'(1);
               else      starve_nxt = '0;
            end else if (iREN) begin
               next_state = I_ACC;
               starve_nxt = '0;
            end
         end
         D_ACC: begin
            // a dropped enable abandons the access without touching the RAM
            if (d_req) begin
               own     = 1'b1;
               ramaddr = daddr;
               if (dWEN) begin
                  ramWEN   = 1'b1;
                  ramstore = dstore;
               end else begin
                  ramREN = 1'b1;
               end
               if (ramstate == RS_ACCESS) begin
                  dhit  = 1'b1;
                  dload = dWEN ? '0 : ramload;
               end
            end else begin
               next_state = IDLE;
            end
         end
         I_ACC: begin
            if (iREN) begin
               own     = 1'b1;
               ramREN  = 1'b1;
               ramaddr = iaddr;
               if (ramstate == RS_ACCESS) begin
                  ihit  = 1'b1;
                  iload = ramload;
               end
            end else begin
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase

      // response handling shared by both access states
      if (own) begin
         case (ramstate)
            RS_ACCESS: next_state = IDLE;
            RS_ERROR: begin
               if (retry_cnt == RLIM) abort = 1'b1;
               else                   retry_nxt = retry_cnt + RW'(1);
            end
            default: begin
               if (tmo_cnt == TLIM) abort = 1'b1;
               else                 tmo_nxt = tmo_cnt + TW'(1);
            end
         endcase
         if (abort) next_state = IDLE;
      end
   end

endmodule
